// File: rtl/cmos_dvp_capture_pkg.sv
// Shared types for the DVP capture block: FSM states and pixel width.
// Optional geometry check is enabled by defining CMOS_SIZE_CHECK_EN.
package cmos_dvp_capture_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int RGB565_W = 16;

endpackage

// File: rtl/cmos_dvp_capture_if.sv
// Pin-side and pixel-stream signals of the DVP capture block.
// slave is the capture side, master is the sensor/consumer side.
interface cmos_dvp_capture_if;

    logic       cmos_vsync;
    logic       cmos_href;
    logic [7:0] cmos_data;

    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [cmos_dvp_capture_pkg::RGB565_W-1:0] post_img_data;

    modport master (
        output cmos_vsync,
        output cmos_href,
        output cmos_data,
        input  post_frame_vsync,
        input  post_frame_href,
        input  post_frame_clken,
        input  post_img_data
    );

    modport slave (
        input  cmos_vsync,
        input  cmos_href,
        input  cmos_data,
        output post_frame_vsync,
        output post_frame_href,
        output post_frame_clken,
        output post_img_data
    );

endinterface

// File: rtl/cmos_sync_edge.sv
// Input register stage: samples sensor pins, derives frame edges.
module cmos_sync_edge #(
    parameter logic VS_VALID = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] data,
    output logic       vs_act,
    output logic       vs_act_d,
    output logic       frame_start,
    output logic       frame_end,
    output logic       href_r,
    output logic [7:0] data_r
);

    logic vsync_r;

    // vsync_r resets to the inactive level so no spurious edge follows reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r  <= ~VS_VALID;
            href_r   <= 1'b0;
            data_r   <= 8'd0;
            vs_act_d <= 1'b0;
        end else begin
            vsync_r  <= vsync;
            href_r   <= href;
            data_r   <= data;
            vs_act_d <= vs_act;
        end
    end

    assign vs_act      = (vsync_r == VS_VALID);
    assign frame_start = vs_act & ~vs_act_d;
    assign frame_end   = ~vs_act & vs_act_d;

endmodule

// File: rtl/cmos_dvp_capture.sv
// DVP receiver: drops settling frames, packs byte pairs into RGB565.
// Define CMOS_SIZE_CHECK_EN to build the line/frame geometry checker.
module cmos_dvp_capture
    import cmos_dvp_capture_pkg::*;
#(
    parameter logic       CMOS_VSYNC_VALID = 1'b1,
    parameter logic [9:0] IMG_HDISP        = 10'd640,
    parameter logic [9:0] IMG_VDISP        = 10'd480,
    parameter logic [3:0] FRAME_SKIP       = 4'd10
) (
    input  logic                clk,
    input  logic                rst_n,
    cmos_dvp_capture_if.slave   dvp,
    output logic [7:0]          frame_cnt,
    output logic                size_err
);

    state_t                state;
    logic [3:0]            skip_cnt;
    logic                  gate;
    logic                  vs_act;
    logic                  vs_act_d;
    logic                  frame_start;
    logic                  frame_end;
    logic                  href_r;
    logic [7:0]            data_r;
    logic                  phase;
    logic [7:0]            hold;
    logic                  pix_vld;
    logic                  href_d;
    logic [RGB565_W-1:0]   pix_data;

    wire px_done = href_r & phase & vs_act;

    cmos_sync_edge #(
        .VS_VALID (CMOS_VSYNC_VALID)
    ) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (dvp.cmos_vsync),
        .href        (dvp.cmos_href),
        .data        (dvp.cmos_data),
        .vs_act      (vs_act),
        .vs_act_d    (vs_act_d),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .href_r      (href_r),
        .data_r      (data_r)
    );

    // gate opens only for frames that start while already in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            skip_cnt  <= 4'd0;
            gate      <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            if (frame_end) begin
                case (state)
                    ST_WAIT: state <= (FRAME_SKIP != 4'd0) ? ST_SKIP : ST_RUN;
                    ST_SKIP: begin
                        if (skip_cnt == FRAME_SKIP - 4'd1)
                            state <= ST_RUN;
                        else
                            skip_cnt <= skip_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end
            if (frame_start)
                gate <= (state == ST_RUN);
            else if (frame_end)
                gate <= 1'b0;
            if (frame_end && gate)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase                <= 1'b0;
            hold                 <= 8'd0;
            pix_vld              <= 1'b0;
            pix_data             <= '0;
            href_d               <= 1'b0;
            dvp.post_frame_vsync <= 1'b0;
            dvp.post_frame_href  <= 1'b0;
            dvp.post_frame_clken <= 1'b0;
            dvp.post_img_data    <= '0;
        end else begin
            phase   <= href_r ? ~phase : 1'b0;
            pix_vld <= px_done;
            href_d  <= href_r & vs_act;
            if (href_r && !phase)
                hold <= data_r;
            if (href_r && phase)
                pix_data <= {hold, data_r};
            dvp.post_frame_vsync <= vs_act_d & gate;
            dvp.post_frame_href  <= href_d & gate;
            dvp.post_frame_clken <= pix_vld & gate;
            if (pix_vld && gate)
                dvp.post_img_data <= pix_data;
        end
    end

`ifdef CMOS_SIZE_CHECK_EN
    logic [10:0] pix_cnt;
    logic [10:0] line_cnt;

    wire line_end = href_d & ~href_r;
    wire line_bad = line_end && (pix_cnt != {1'b0, IMG_HDISP});
    wire frm_bad  = frame_end && (line_cnt != {1'b0, IMG_VDISP});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= 11'd0;
            line_cnt <= 11'd0;
            size_err <= 1'b0;
        end else begin
            if (frame_start) begin
                pix_cnt  <= 11'd0;
                line_cnt <= 11'd0;
            end else if (line_end) begin
                pix_cnt  <= 11'd0;
                line_cnt <= line_cnt + 11'd1;
            end else if (px_done) begin
                pix_cnt <= pix_cnt + 11'd1;
            end
            if (frame_start && state == ST_RUN)
                size_err <= 1'b0;
            else if (gate && (line_bad || frm_bad))
                size_err <= 1'b1;
        end
    end
`else
    wire unused_geom = ^{IMG_HDISP, IMG_VDISP};

    assign size_err = 1'b0;
`endif

endmodule
